// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Instruction-memory request/response bundle used by the
//               fetch queue.
//                 req   - request valid (driven by the fetch queue)
//                 addr  - 30-bit word address (fetch PC [31:2])
//                 ack   - response valid, qualified by req
//                 rdata - instruction word, valid with ack
//               master : fetch queue side, slave : memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if;
  logic        req;
  logic [29:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction prefetch queue feeding the F/D pipeline register.
//               Owns the fetch PC, issues word requests over a req/ack bus,
//               buffers returned words with their PCs in a DEPTH-entry FIFO
//               and presents the head to decode. Redirects flush the FIFO
//               and abandon any in-flight response.
// Ports       : clk, rst_n        - clock, asynchronous active-low reset
//               redirect_i        - PC change request from decode
//               redirect_pc_i     - new fetch PC (bits [1:0] ignored)
//               stall_i           - decode stall, head entry held
//               imem              - instruction memory bus (master side)
//               valid_o           - head entry valid
//               instr_o           - head instruction (0 when not valid)
//               pc_o, pc_plus4_o  - head PC and PC+4 (0 when not valid)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        redirect_i,
  input  wire logic [31:0] redirect_pc_i,
  input  wire logic        stall_i,
  fetch_queue_if.master    imem,
  output logic             valid_o,
  output logic [31:0]      instr_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t         state_q;
  logic [31:0]    fpc_q;
  logic [29:0]    drop_addr_q;
  logic [CW-1:0]  count_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [PW-1:0]  wr_ptr_q;
  logic [31:0]    mem_instr_q [DEPTH];
  logic [29:0]    mem_pc_q    [DEPTH];

  logic           w_valid;
  logic           w_ack;
  logic           w_push;
  logic           w_pop;
  logic [CW-1:0]  count_d;
  logic [31:0]    w_target;
  logic [31:0]    w_head_pc;
  logic           w_unused_pc_lsb;

  assign w_valid  = (count_q != '0);
  // ack only means something while a request is on the bus
  assign w_ack    = imem.ack & imem.req;
  assign w_push   = (state_q == S_WAIT) & w_ack & ~redirect_i;
  assign w_pop    = w_valid & ~stall_i & ~redirect_i;
  assign count_d  = count_q + CW'(w_push) - CW'(w_pop);
  assign w_target = {redirect_pc_i[31:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      fpc_q       <= {RESET_PC[31:2], 2'b00};
      drop_addr_q <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (w_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      count_q <= count_d;
      // flush: realigning both pointers to zero keeps them consistent
      if (redirect_i) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end

      case (state_q)
        S_IDLE: begin
          if (redirect_i)             fpc_q   <= w_target;
          else if (count_q < C_FULL)  state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (redirect_i) begin
            fpc_q <= w_target;
            if (w_ack) begin
              state_q <= S_IDLE;
            end else begin
              // keep presenting the abandoned address until its ack arrives
              state_q     <= S_DROP;
              drop_addr_q <= fpc_q[31:2];
            end
          end else if (w_ack) begin
            fpc_q <= fpc_q + 32'd4;
            if (!(count_d < C_FULL)) state_q <= S_IDLE;
          end
        end
        S_DROP: begin
          if (redirect_i) fpc_q   <= w_target;
          if (w_ack)      state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // storage needs no reset: every read is qualified by count_q
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_instr_q[wr_ptr_q] <= imem.rdata;
      mem_pc_q[wr_ptr_q]    <= fpc_q[31:2];
    end
  end

  assign imem.req  = (state_q == S_WAIT) | (state_q == S_DROP);
  assign imem.addr = (state_q == S_WAIT) ? fpc_q[31:2] :
                     (state_q == S_DROP) ? drop_addr_q : 30'd0;

  assign w_head_pc  = {mem_pc_q[rd_ptr_q], 2'b00};
  assign valid_o    = w_valid;
  assign instr_o    = w_valid ? mem_instr_q[rd_ptr_q] : 32'd0;
  assign pc_o       = w_valid ? w_head_pc : 32'd0;
  assign pc_plus4_o = w_valid ? (w_head_pc + 32'd4) : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue. Random memory latency,
//               stalls and redirects are applied and every output is compared
//               each cycle with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        stall_i;
  logic        valid_o;
  logic [31:0] instr_o, pc_o, pc_plus4_o;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .imem          (bus),
    .valid_o       (valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o)
  );

  always #5 clk = ~clk;

  // reference model state
  ent_t        q[$];
  logic [31:0] m_fpc;
  logic        m_busy;   // a request is on the bus
  logic        m_drop;   // that request has been abandoned
  logic [29:0] m_addr;   // address of the request on the bus

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] mem_data(input logic [29:0] a);
    return {a, 2'b00} ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fpc  = {RESET_PC[31:2], 2'b00};
    m_busy = 1'b0;
    m_drop = 1'b0;
    m_addr = '0;
  endtask

  task automatic check_outputs();
    logic hv;
    hv = (q.size() > 0);
    check("req",      {31'd0, bus.req},  {31'd0, m_busy});
    check("addr",     {2'b00, bus.addr}, m_busy ? {2'b00, m_addr} : 32'd0);
    check("valid",    {31'd0, valid_o},  {31'd0, hv});
    check("instr",    instr_o,           hv ? q[0].instr : 32'd0);
    check("pc",       pc_o,              hv ? q[0].pc : 32'd0);
    check("pc_plus4", pc_plus4_o,        hv ? q[0].pc + 32'd4 : 32'd0);
  endtask

  // next state of the model for one clock edge with the given inputs
  task automatic model_update(input logic ack, input logic redir,
                              input logic [31:0] rpc, input logic stall);
    int          n;
    logic        pop, pushed;
    logic [31:0] tgt;
    n      = q.size();
    pop    = (n > 0) && !stall && !redir;
    pushed = 1'b0;
    tgt    = {rpc[31:2], 2'b00};
    if (!m_busy) begin
      if (redir) m_fpc = tgt;
      else if (n < DEPTH) begin
        m_busy = 1'b1;
        m_addr = m_fpc[31:2];
      end
    end else if (!m_drop) begin
      if (redir) begin
        m_fpc = tgt;
        if (ack) m_busy = 1'b0;
        else     m_drop = 1'b1;
      end else if (ack) begin
        if (pop) void'(q.pop_front());
        q.push_back('{instr: mem_data(m_addr), pc: m_fpc});
        pushed = 1'b1;
        m_fpc  = m_fpc + 32'd4;
        m_addr = m_fpc[31:2];
        if (q.size() >= DEPTH) m_busy = 1'b0;
      end
    end else begin
      if (redir) m_fpc = tgt;
      if (ack) begin
        m_busy = 1'b0;
        m_drop = 1'b0;
      end
    end
    if (redir) q.delete();
    else if (pop && !pushed) void'(q.pop_front());
  endtask

  // called at a falling edge: check, drive, advance model, move to next falling edge
  task automatic step(input int p_ack, input int p_stall, input int p_redir);
    logic        a, r, s;
    logic [31:0] rpc;
    check_outputs();
    a = m_busy && (($urandom % 100) < p_ack);
    r = (($urandom % 100) < p_redir);
    s = (($urandom % 100) < p_stall);
    rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
    redirect_i    = r;
    redirect_pc_i = rpc;
    stall_i       = s;
    bus.ack       = a;
    bus.rdata     = mem_data(bus.addr);
    model_update(a, r, rpc, s);
    @(negedge clk);
  endtask

  initial begin
    logic found;
    rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; stall_i = 1'b0;
    bus.ack = 1'b0; bus.rdata = '0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // zero-wait memory, free-flowing decode
    repeat (30) step(100, 0, 0);
    // hold decode until full, then drain
    repeat (12) step(100, 100, 0);
    repeat (12) step(100, 0, 0);
    // variable latency with stalls and redirects
    repeat (200) step(35, 20, 8);

    // build up three entries with a request still open, then reset
    found = 1'b0;
    repeat (4) step(100, 0, 100);
    for (int i = 0; i < 50 && !found; i++) begin
      if (q.size() == 3 && m_busy && !m_drop) found = 1'b1;
      else step(100, 100, 0);
    end
    check("rst_setup", {31'd0, found}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) step(100, 0, 0);

    repeat (300) step(60, 40, 5);

    // full queue, then pop and redirect on the same edge
    repeat (12) step(100, 100, 0);
    check("full_cnt", q.size(), DEPTH);
    step(100, 0, 100);
    repeat (15) step(100, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
